// File: rtl/one_hot_dispatch_pkg.sv
// one_hot_dispatch_pkg
//   Shared constants and helpers for the one-hot dispatch block and the
//   mux-side checkers that validate the same select encoding.
//   - WIDTH_DEF / CNT_DEF / ERR_CNT_W_DEF : default parameter values
//   - log2          : ceil(log2(n)), minimum 1
//   - onehot_legal  : 1 when the select has exactly one bit set
package one_hot_dispatch_pkg;

    localparam int WIDTH_DEF     = 32;
    localparam int CNT_DEF       = 5;
    localparam int ERR_CNT_W_DEF = 8;

    // Widest select the shared checker accepts; narrower selects are zero-extended.
    localparam int SEL_MAX = 64;

    function automatic int log2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Zero-extension does not change legality: x!=0 and x&(x-1)==0.
    function automatic logic onehot_legal(input logic [SEL_MAX-1:0] sel);
        return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/one_hot_dispatch_lane.sv
// one_hot_dispatch_lane
//   Single-entry output slot. A load always wins over a drain so a lane can
//   accept a new payload in the same cycle its current one leaves.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     load              write data_in into the slot
//     data_in [WIDTH]   payload to store
//     out_valid         slot holds a payload
//     out_ready         consumer accepts the payload
//     out_data [WIDTH]  stored payload (held while empty)
module one_hot_dispatch_lane #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = data_in;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/one_hot_dispatch.sv
// one_hot_dispatch
//   Scatters one valid/ready stream to one of CNT single-entry lanes chosen
//   by a one-hot select. Zero or multi-hot selects are accepted and dropped,
//   signalled by a one-cycle err pulse.
//   Optional macro ONE_HOT_DISPATCH_ERR_CNT_EN adds a saturating drop counter
//   (err_cnt) with a synchronous clear (err_clr, wins over increment).
//   Ports:
//     clk, rst_n               clock, async active-low reset
//     in_valid/in_ready        upstream handshake
//     in_data [WIDTH]          payload
//     in_sel [CNT]             one-hot destination lane
//     out_valid/out_ready[CNT] per-lane handshake
//     out_data [CNT][WIDTH]    per-lane payload
//     err                      illegal transfer dropped (one-cycle pulse)
//     err_clr, err_cnt         drop counter clear / value (macro only)
module one_hot_dispatch
    import one_hot_dispatch_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CNT       = CNT_DEF
`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
    ,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [CNT-1:0]            in_sel,
    output logic [CNT-1:0]            out_valid,
    input  logic [CNT-1:0]            out_ready,
    output logic [CNT-1:0][WIDTH-1:0] out_data,
`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
    input  logic                      err_clr,
    output logic [ERR_CNT_W-1:0]      err_cnt,
`endif
    output logic                      err
);

    logic [SEL_MAX-1:0] sel_ext;
    logic               legal;
    logic [CNT-1:0]     free;
    logic               fire;
    logic [CNT-1:0]     load;
    logic               drop;
    logic               err_q;

    assign sel_ext = {{(SEL_MAX-CNT){1'b0}}, in_sel};
    assign legal   = onehot_legal(sel_ext);
    assign free    = ~out_valid | out_ready;

    // Illegal selects are always taken so a bad request cannot stall the stream.
    assign in_ready = legal ? |(free & in_sel) : 1'b1;
    assign fire     = in_valid && in_ready;
    assign load     = (fire && legal) ? in_sel : '0;
    assign drop     = fire && !legal;

    for (genvar i = 0; i < CNT; i++) begin : g_lane
        one_hot_dispatch_lane #(.WIDTH(WIDTH)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[i]),
            .data_in  (in_data),
            .out_valid(out_valid[i]),
            .out_ready(out_ready[i]),
            .out_data (out_data[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= drop;
    end

    assign err = err_q;

`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr)                  err_cnt_d = '0;
        else if (drop && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_one_hot_dispatch.sv
module tb_one_hot_dispatch;

    localparam int WIDTH = 32;
    localparam int CNT   = 5;
    localparam int ECW   = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [CNT-1:0]            in_sel;
    logic [CNT-1:0]            out_valid;
    logic [CNT-1:0]            out_ready;
    logic [CNT-1:0][WIDTH-1:0] out_data;
    logic                      err;
    logic                      err_clr;
    logic [ECW-1:0]            err_cnt_obs;

    int errors = 0;
    int checks = 0;

    // Reference state: what each lane should be holding.
    logic [CNT-1:0]            m_valid;
    logic [CNT-1:0][WIDTH-1:0] m_data;
    logic                      m_err;
    int                        m_cnt;

    always #5 clk = ~clk;

`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
    logic [ECW-1:0] err_cnt;
    assign err_cnt_obs = err_cnt;
    one_hot_dispatch #(.WIDTH(WIDTH), .CNT(CNT), .ERR_CNT_W(ECW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err_clr(err_clr),
        .err_cnt(err_cnt), .err(err));
`else
    assign err_cnt_obs = '0;
    one_hot_dispatch #(.WIDTH(WIDTH), .CNT(CNT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .err(err));
`endif

    task automatic model_reset();
        m_valid = '0;
        m_data  = '0;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock: drive at negedge, check everything, then advance the model.
    task automatic cycle(input logic v, input logic [CNT-1:0] sel,
                         input logic [WIDTH-1:0] d, input logic [CNT-1:0] ordy,
                         input logic clr);
        int  lane;
        bit  legal, exp_rdy, fire;
        in_valid  = v;
        in_sel    = sel;
        in_data   = d;
        out_ready = ordy;
        err_clr   = clr;
        #1;
        legal = ($countones(sel) == 1);
        lane  = 0;
        for (int i = 0; i < CNT; i++) if (sel[i]) lane = i;
        exp_rdy = legal ? (!m_valid[lane] || ordy[lane]) : 1'b1;
        checks++;
        if (in_ready !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready: got %b want %b (sel=%b)", in_ready, exp_rdy, sel);
        end
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL out_valid: got %b want %b", out_valid, m_valid);
        end
        checks++;
        if (out_data !== m_data) begin
            errors++;
            $display("FAIL out_data: got %h want %h", out_data, m_data);
        end
        checks++;
        if (err !== m_err) begin
            errors++;
            $display("FAIL err: got %b want %b", err, m_err);
        end
`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
        checks++;
        if (err_cnt_obs !== ECW'(m_cnt)) begin
            errors++;
            $display("FAIL err_cnt: got %0d want %0d", err_cnt_obs, m_cnt);
        end
`endif
        @(posedge clk);
        fire = v && exp_rdy;
        for (int i = 0; i < CNT; i++) begin
            if (fire && legal && i == lane) begin
                m_valid[i] = 1'b1;
                m_data[i]  = d;
            end else if (m_valid[i] && ordy[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        m_err = fire && !legal;
        if (clr) m_cnt = 0;
        else if (m_err && m_cnt < (1 << ECW) - 1) m_cnt++;
        @(negedge clk);
    endtask

    task automatic idle(input logic [CNT-1:0] ordy);
        cycle(1'b0, '0, '0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_sel = '0; in_data = '0; out_ready = '0; err_clr = 0;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== '0 || out_data !== '0 || err !== 1'b0 || err_cnt_obs !== '0) begin
            errors++;
            $display("FAIL reset: valid=%b err=%b cnt=%0d data=%h", out_valid, err, err_cnt_obs, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        cycle(1'b1, 5'b00100, 32'hDEAD_BEEF, '1, 1'b0);
        checks++;
        if (out_valid !== 5'b00100 || out_data[2] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL single_load: valid=%b data2=%h want 00100/deadbeef", out_valid, out_data[2]);
        end
        idle('1);
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL single_drain: valid=%b want 00000", out_valid);
        end
    endtask

    task automatic test_blocked();
        cycle(1'b1, 5'b00010, 32'h1111_0001, '0, 1'b0);
        cycle(1'b1, 5'b00010, 32'h2222_0002, '0, 1'b0);   // must be refused
        cycle(1'b1, 5'b01000, 32'h3333_0003, '0, 1'b0);   // other lane unaffected
        checks++;
        if (out_data[1] !== 32'h1111_0001 || out_valid !== 5'b01010) begin
            errors++;
            $display("FAIL blocked_lane: valid=%b data1=%h want 01010/11110001", out_valid, out_data[1]);
        end
        idle('1);
        idle('1);
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 5'b00001, 32'd1, '1, 1'b0);
        for (int k = 2; k <= 3; k++) begin
            cycle(1'b1, 5'b00001, WIDTH'(k), '1, 1'b0);
            checks++;
            if (out_valid[0] !== 1'b1 || out_data[0] !== WIDTH'(k)) begin
                errors++;
                $display("FAIL back_to_back: valid0=%b data0=%0d want 1/%0d", out_valid[0], out_data[0], k);
            end
        end
        idle('1);
    endtask

    task automatic test_illegal();
        cycle(1'b1, 5'b00000, 32'hBAD0_0000, '1, 1'b0);
        cycle(1'b1, 5'b01100, 32'hBAD0_0001, '1, 1'b0);
        checks++;
        if (err !== 1'b1 || out_valid !== '0) begin
            errors++;
            $display("FAIL illegal_drop: err=%b valid=%b want 1/00000", err, out_valid);
        end
        idle('1);
`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
        checks++;
        if (err_cnt_obs !== 2'd2) begin
            errors++;
            $display("FAIL illegal_count: got %0d want 2", err_cnt_obs);
        end
`endif
        idle('1);
    endtask

`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
    task automatic test_saturate();
        cycle(1'b0, '0, '0, '1, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 5'b00011, WIDTH'(k), '1, 1'b0);
        checks++;
        if (err_cnt_obs !== 2'd3) begin
            errors++;
            $display("FAIL saturate: got %0d want 3", err_cnt_obs);
        end
        cycle(1'b1, 5'b00000, '0, '1, 1'b1);
        checks++;
        if (err_cnt_obs !== 2'd0 || err !== 1'b1) begin
            errors++;
            $display("FAIL clear_priority: cnt=%0d err=%b want 0/1", err_cnt_obs, err);
        end
        idle('1);
    endtask
`endif

    task automatic test_random();
        logic [CNT-1:0] sel;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) < 7) sel = CNT'(1) << $urandom_range(0, CNT - 1);
            else                          sel = CNT'($urandom_range(0, (1 << CNT) - 1));
            cycle(1'($urandom_range(0, 3) != 0), sel, $urandom,
                  CNT'($urandom), 1'($urandom_range(0, 15) == 0));
        end
        idle('1);
        idle('1);
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 5'b00001, 32'hA0, '0, 1'b0);
        cycle(1'b1, 5'b00100, 32'hA2, '0, 1'b0);
        cycle(1'b1, 5'b10000, 32'hA4, '0, 1'b0);
        checks++;
        if (out_valid !== 5'b10101) begin
            errors++;
            $display("FAIL reset_mid_fill: valid=%b want 10101", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== '0) begin
            errors++;
            $display("FAIL reset_mid_async: valid=%b want 00000", out_valid);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_blocked();
        test_back_to_back();
        test_illegal();
`ifdef ONE_HOT_DISPATCH_ERR_CNT_EN
        test_saturate();
`endif
        test_random();
        test_reset_mid();
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
